// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//
// Shared definitions for the push-button conditioner:
//   - channel index constants for the board buttons,
//   - default timing for a 100 MHz system clock,
//   - reduced timing used when simulating,
//   - repeat phase encoding and a small integer helper.
//
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

    // Board button channel indices
    localparam int NUM_BTN    = 5;
    localparam int BTN_LEFT   = 0;
    localparam int BTN_CENTER = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_TOP    = 3;
    localparam int BTN_BOTTOM = 4;

    // Hardware timing at 100 MHz
    localparam int CLK_HZ              = 100_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;    // 500 ms
    localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;   // 100 ms

    // Short timing so simulations stay fast
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 10;
    localparam int SIM_REPEAT_PERIOD   = 3;

    // Auto-repeat phase: waiting for the long initial delay, or in the
    // periodic phase. The periodic encoding is 0 so reset clears it.
    typedef enum logic {
        RPT_PERIODIC = 1'b0,
        RPT_FIRST    = 1'b1
    } rpt_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
//
// One conditioned button: 2-flop synchroniser, counter debouncer, one-cycle
// press/release pulses and optional auto-repeat while held.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   raw asynchronous button input, active-high
//   repeat_en   in   auto-repeat enable (synchronous to clk)
//   btn_level   out  debounced level
//   btn_press   out  one-cycle pulse on accepted 0->1
//   btn_release out  one-cycle pulse on accepted 1->0
//   btn_repeat  out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RP_W    = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_LAST  = RP_W'(REPEAT_PERIOD - 1);

    logic            s1_p0;
    logic            sync_p1;
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rcnt;
    rpt_phase_t      phase;

    logic accept;
    logic accept_press;
    logic accept_release;
    logic rpt_due;

    // A change is accepted on the edge where the mismatch has already been
    // counted DEBOUNCE_CYCLES-1 times, i.e. it held for DEBOUNCE_CYCLES edges.
    assign accept         = (sync_p1 != btn_level) && (db_cnt == DB_LAST);
    assign accept_press   = accept && sync_p1;
    assign accept_release = accept && !sync_p1;

    assign rpt_due = btn_level && repeat_en &&
                     (((phase == RPT_FIRST)    && (rcnt == RD_LAST)) ||
                      ((phase == RPT_PERIODIC) && (rcnt == RP_LAST)));

    // ---- stage p0/p1: synchroniser ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p0   <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            s1_p0   <= btn_raw;
            sync_p1 <= s1_p0;
        end
    end

    // ---- debounce and edge pulses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_level   <= 1'b0;
            db_cnt      <= '0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= accept_press;
            btn_release <= accept_release;
            if (sync_p1 == btn_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                btn_level <= sync_p1;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // ---- auto-repeat ----
    // Any accepted edge, a low level or a disabled channel rearms the full
    // initial delay. Checking the accepted release first makes release win
    // over a repeat that falls due on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt       <= '0;
            phase      <= RPT_PERIODIC;
            btn_repeat <= 1'b0;
        end else begin
            btn_repeat <= 1'b0;
            if (accept_press || accept_release || !btn_level || !repeat_en) begin
                rcnt  <= '0;
                phase <= RPT_FIRST;
            end else if (rpt_due) begin
                btn_repeat <= 1'b1;
                rcnt       <= '0;
                phase      <= RPT_PERIODIC;
            end else begin
                rcnt <= rcnt + RP_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Multi-channel conditioner for push-buttons and other slow mechanical
// inputs. Each channel is an independent button_channel.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   [NUM_CH] raw asynchronous inputs, active-high
//   repeat_en   in   [NUM_CH] per-channel auto-repeat enable
//   btn_level   out  [NUM_CH] debounced levels
//   btn_press   out  [NUM_CH] one-cycle pulses on accepted 0->1
//   btn_release out  [NUM_CH] one-cycle pulses on accepted 1->0
//   btn_repeat  out  [NUM_CH] one-cycle auto-repeat pulses while held
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_CH          = NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] btn_raw,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .repeat_en   (repeat_en[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule
